id_hazard: RTL and testbench

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of the instruction-fetch stage. Consumes `Instruc_IFID`/`PC_IFID`, reads the 32×32 register file, generates immediate and control, and registers everything into the ID/EX pipeline register. Also owns hazard control. It drives `PCWrite`, `Write_IFID` and `flush_IF` back to fetch for load-use stalls and taken-branch flushes.

---
 rtl/id_hazard.sv | 258 +++++++++++++++++++++++++
 tb/tb_id_hazard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard.sv
// RV32I instruction-decode stage with register file, ID/EX pipeline register and
// load-use / taken-branch hazard control. Optional macro: ID_WB_BYPASS_EN (WB->ID read bypass).
module id_hazard (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruc_IFID,
  input  logic [31:0] PC_IFID,
  input  logic        RegWrite_WB,
  input  logic [4:0]  Rd_WB,
  input  logic [31:0] Result_WB,
  input  logic        PCSrc_EX,
  output logic        PCWrite,
  output logic        Write_IFID,
  output logic        flush_IF,
  output logic [31:0] RD1_IDEX,
  output logic [31:0] RD2_IDEX,
  output logic [31:0] Imm_IDEX,
  output logic [31:0] PC_IDEX,
  output logic [4:0]  Rs1_IDEX,
  output logic [4:0]  Rs2_IDEX,
  output logic [4:0]  Rd_IDEX,
  output logic [2:0]  Funct3_IDEX,
  output logic [3:0]  ALUCtrl_IDEX,
  output logic [1:0]  ResultSrc_IDEX,
  output logic        RegWrite_IDEX,
  output logic        MemRead_IDEX,
  output logic        MemWrite_IDEX,
  output logic        Branch_IDEX,
  output logic        Jump_IDEX,
  output logic        ALUSrcB_IDEX,
  output logic        ALUSrcA_PC_IDEX
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [31:0] r_regs [32];

  logic [31:0] r_rd1, r_rd2, r_imm, r_pc;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [2:0]  r_f3;
  logic [3:0]  r_aluctrl;
  logic [1:0]  r_resultsrc;
  logic        r_regwrite, r_memread, r_memwrite, r_branch, r_jump, r_alusrcb, r_alusrca_pc;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_f3;
  logic [31:0] w_inst, w_imm, w_rd1, w_rd2;
  logic [3:0]  w_aluctrl;
  logic [1:0]  w_resultsrc;
  logic        w_regwrite, w_memread, w_memwrite, w_branch, w_jump, w_alusrcb, w_alusrca_pc;
  logic        w_use_rs1, w_use_rs2, w_hz, w_bubble;

  assign w_inst   = Instruc_IFID;
  assign w_opcode = w_inst[6:0];
  assign w_rd     = w_inst[11:7];
  assign w_f3     = w_inst[14:12];
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];

  // Instruction decode: control, immediate and operand-use flags
  always_comb begin
    w_imm        = 32'd0;
    w_aluctrl    = ALU_ADD;
    w_resultsrc  = 2'd0;
    w_regwrite   = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alusrcb    = 1'b0;
    w_alusrca_pc = 1'b0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1;
        w_aluctrl  = alu_op(w_f3, w_inst[30]);
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OP_I: begin
        w_imm      = {{20{w_inst[31]}}, w_inst[31:20]};
        w_regwrite = 1'b1;
        w_alusrcb  = 1'b1;
        w_aluctrl  = alu_op(w_f3, (w_f3 == 3'b101) && w_inst[30]);
        w_use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        w_imm       = {{20{w_inst[31]}}, w_inst[31:20]};
        w_regwrite  = 1'b1;
        w_memread   = 1'b1;
        w_alusrcb   = 1'b1;
        w_resultsrc = 2'd1;
        w_use_rs1   = 1'b1;
      end
      OP_STORE: begin
        w_imm      = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
        w_memwrite = 1'b1;
        w_alusrcb  = 1'b1;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OP_BR: begin
        w_imm     = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_branch  = 1'b1;
        w_aluctrl = ALU_SUB;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_imm        = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_regwrite   = 1'b1;
        w_jump       = 1'b1;
        w_alusrcb    = 1'b1;
        w_alusrca_pc = 1'b1;
        w_resultsrc  = 2'd2;
      end
      OP_JALR: begin
        w_imm       = {{20{w_inst[31]}}, w_inst[31:20]};
        w_regwrite  = 1'b1;
        w_jump      = 1'b1;
        w_alusrcb   = 1'b1;
        w_resultsrc = 2'd2;
        w_use_rs1   = 1'b1;
      end
      OP_LUI: begin
        w_imm      = {w_inst[31:12], 12'd0};
        w_regwrite = 1'b1;
        w_alusrcb  = 1'b1;
        w_aluctrl  = ALU_PASS;
      end
      OP_AUIPC: begin
        w_imm        = {w_inst[31:12], 12'd0};
        w_regwrite   = 1'b1;
        w_alusrcb    = 1'b1;
        w_alusrca_pc = 1'b1;
      end
      default: begin
        w_imm = 32'd0;
      end
    endcase
  end

  // Register-file read ports; x0 is hard-wired to zero
  always_comb begin
    w_rd1 = 32'd0;
    w_rd2 = 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (w_rs1 == 5'd0) w_rd1 = 32'd0;
    else if (RegWrite_WB && (Rd_WB == w_rs1)) w_rd1 = Result_WB;
    else w_rd1 = r_regs[w_rs1];
    if (w_rs2 == 5'd0) w_rd2 = 32'd0;
    else if (RegWrite_WB && (Rd_WB == w_rs2)) w_rd2 = Result_WB;
    else w_rd2 = r_regs[w_rs2];
`else
    if (w_rs1 == 5'd0) w_rd1 = 32'd0;
    else w_rd1 = r_regs[w_rs1];
    if (w_rs2 == 5'd0) w_rd2 = 32'd0;
    else w_rd2 = r_regs[w_rs2];
`endif
  end

  // Register-file write port and reset clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (RegWrite_WB && (Rd_WB != 5'd0)) begin
      r_regs[Rd_WB] <= Result_WB;
    end
  end

  // A taken branch overrides the load-use stall; reset forces the normal fetch controls
  assign w_hz = !rst && r_memread && (r_rd != 5'd0) &&
                ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));
  assign w_bubble   = PCSrc_EX || w_hz;
  assign PCWrite    = PCSrc_EX || !w_hz;
  assign Write_IFID = PCSrc_EX || !w_hz;
  assign flush_IF   = PCSrc_EX && !rst;

  // ID/EX pipeline register; bubbles zero only the control fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= 32'd0; r_rd2 <= 32'd0; r_imm <= 32'd0; r_pc <= 32'd0;
      r_rs1 <= 5'd0;  r_rs2 <= 5'd0;  r_rd  <= 5'd0;  r_f3 <= 3'd0;
      r_aluctrl <= 4'd0; r_resultsrc <= 2'd0;
      r_regwrite <= 1'b0; r_memread <= 1'b0; r_memwrite <= 1'b0; r_branch <= 1'b0;
      r_jump <= 1'b0; r_alusrcb <= 1'b0; r_alusrca_pc <= 1'b0;
    end else begin
      r_rd1 <= w_rd1; r_rd2 <= w_rd2; r_imm <= w_imm; r_pc <= PC_IFID;
      r_rs1 <= w_rs1; r_rs2 <= w_rs2; r_rd  <= w_rd;  r_f3 <= w_f3;
      r_aluctrl    <= w_bubble ? 4'd0 : w_aluctrl;
      r_resultsrc  <= w_bubble ? 2'd0 : w_resultsrc;
      r_regwrite   <= w_regwrite   && !w_bubble;
      r_memread    <= w_memread    && !w_bubble;
      r_memwrite   <= w_memwrite   && !w_bubble;
      r_branch     <= w_branch     && !w_bubble;
      r_jump       <= w_jump       && !w_bubble;
      r_alusrcb    <= w_alusrcb    && !w_bubble;
      r_alusrca_pc <= w_alusrca_pc && !w_bubble;
    end
  end

  assign RD1_IDEX        = r_rd1;
  assign RD2_IDEX        = r_rd2;
  assign Imm_IDEX        = r_imm;
  assign PC_IDEX         = r_pc;
  assign Rs1_IDEX        = r_rs1;
  assign Rs2_IDEX        = r_rs2;
  assign Rd_IDEX         = r_rd;
  assign Funct3_IDEX     = r_f3;
  assign ALUCtrl_IDEX    = r_aluctrl;
  assign ResultSrc_IDEX  = r_resultsrc;
  assign RegWrite_IDEX   = r_regwrite;
  assign MemRead_IDEX    = r_memread;
  assign MemWrite_IDEX   = r_memwrite;
  assign Branch_IDEX     = r_branch;
  assign Jump_IDEX       = r_jump;
  assign ALUSrcB_IDEX    = r_alusrcb;
  assign ALUSrcA_PC_IDEX = r_alusrca_pc;

endmodule

// File: tb/tb_id_hazard.sv
// Scoreboard bench for id_hazard: directed steps push hand-computed expectations,
// a negedge monitor pops and compares them when they fall due.
module tb_id_hazard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instruc_IFID = 32'd0, PC_IFID = 32'd0, Result_WB = 32'd0;
  logic        RegWrite_WB = 1'b0, PCSrc_EX = 1'b0;
  logic [4:0]  Rd_WB = 5'd0;
  logic        PCWrite, Write_IFID, flush_IF;
  logic [31:0] RD1_IDEX, RD2_IDEX, Imm_IDEX, PC_IDEX;
  logic [4:0]  Rs1_IDEX, Rs2_IDEX, Rd_IDEX;
  logic [2:0]  Funct3_IDEX;
  logic [3:0]  ALUCtrl_IDEX;
  logic [1:0]  ResultSrc_IDEX;
  logic        RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, Branch_IDEX, Jump_IDEX;
  logic        ALUSrcB_IDEX, ALUSrcA_PC_IDEX;

  id_hazard dut (
    .clk(clk), .rst(rst), .Instruc_IFID(Instruc_IFID), .PC_IFID(PC_IFID),
    .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB), .Result_WB(Result_WB), .PCSrc_EX(PCSrc_EX),
    .PCWrite(PCWrite), .Write_IFID(Write_IFID), .flush_IF(flush_IF),
    .RD1_IDEX(RD1_IDEX), .RD2_IDEX(RD2_IDEX), .Imm_IDEX(Imm_IDEX), .PC_IDEX(PC_IDEX),
    .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX), .Rd_IDEX(Rd_IDEX), .Funct3_IDEX(Funct3_IDEX),
    .ALUCtrl_IDEX(ALUCtrl_IDEX), .ResultSrc_IDEX(ResultSrc_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .Branch_IDEX(Branch_IDEX), .Jump_IDEX(Jump_IDEX), .ALUSrcB_IDEX(ALUSrcB_IDEX),
    .ALUSrcA_PC_IDEX(ALUSrcA_PC_IDEX)
  );

  always #5 clk = ~clk;

  // {RegWrite,MemRead,MemWrite,Branch,Jump,ALUSrcB,ALUSrcA_PC,ResultSrc[1:0],ALUCtrl[3:0]}
  localparam logic [12:0] C_ZERO = 13'b0000000000000;
  localparam logic [12:0] C_R    = 13'b1000000000000;
  localparam logic [12:0] C_I    = 13'b1000010000000;
  localparam logic [12:0] C_LW   = 13'b1100010010000;
  localparam logic [12:0] C_LUI  = 13'b1000010001010;
  localparam logic [12:0] C_BEQ  = 13'b0001000000001;
  localparam logic [12:0] C_JAL  = 13'b1000111100000;
  localparam logic [12:0] C_SW   = 13'b0010010000000;
  localparam logic [12:0] C_SRA  = 13'b1000000000111;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_X5 = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_X5 = 32'h00000055;
`endif

  typedef struct {
    int          due;
    int          tag;
    bit          chk_hz, chk_ctl, chk_rd, chk_fld;
    logic [2:0]  hz;
    logic [12:0] ctl;
    logic [31:0] rd1, rd2, imm, pc;
    logic [17:0] idx;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step%0d %s: got %h want %h", tag, nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compare every expectation due in the current cycle
  exp_t m_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      m_e = q.pop_front();
      if (m_e.due < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL step%0d stale: got cycle %0d want %0d", m_e.tag, cyc, m_e.due);
      end else begin
        if (m_e.chk_hz)  chk(m_e.tag, "pcw_wif_flush", {29'd0, PCWrite, Write_IFID, flush_IF}, {29'd0, m_e.hz});
        if (m_e.chk_ctl) chk(m_e.tag, "ctl", {19'd0, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX,
                             Branch_IDEX, Jump_IDEX, ALUSrcB_IDEX, ALUSrcA_PC_IDEX,
                             ResultSrc_IDEX, ALUCtrl_IDEX}, {19'd0, m_e.ctl});
        if (m_e.chk_rd) begin
          chk(m_e.tag, "rd1", RD1_IDEX, m_e.rd1);
          chk(m_e.tag, "rd2", RD2_IDEX, m_e.rd2);
        end
        if (m_e.chk_fld) begin
          chk(m_e.tag, "imm", Imm_IDEX, m_e.imm);
          chk(m_e.tag, "pc", PC_IDEX, m_e.pc);
          chk(m_e.tag, "rs1_rs2_rd_f3", {14'd0, Rs1_IDEX, Rs2_IDEX, Rd_IDEX, Funct3_IDEX}, {14'd0, m_e.idx});
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic br);
    @(posedge clk);
    #1;
    rst = r; Instruc_IFID = ins; PC_IFID = pc;
    RegWrite_WB = wbe; Rd_WB = wbrd; Result_WB = wbd; PCSrc_EX = br;
  endtask

  // Hazard outputs are due this cycle; ID/EX contents after the next edge
  task automatic expect_step(input int tag, input logic [2:0] hz, input logic [12:0] ctl,
                             input bit crd, input logic [31:0] rd1, input logic [31:0] rd2,
                             input bit cfl, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [2:0] f3);
    exp_t e;
    e = '{due: cyc, tag: tag, chk_hz: 1'b1, chk_ctl: 1'b0, chk_rd: 1'b0, chk_fld: 1'b0,
          hz: hz, ctl: 13'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0, pc: 32'd0, idx: 18'd0};
    q.push_back(e);
    e = '{due: cyc + 1, tag: tag, chk_hz: 1'b0, chk_ctl: 1'b1, chk_rd: crd, chk_fld: cfl,
          hz: 3'd0, ctl: ctl, rd1: rd1, rd2: rd2, imm: imm, pc: pc, idx: {rs1, rs2, rd, f3}};
    q.push_back(e);
  endtask

  initial begin
    // reset held two cycles with addi in IF/ID
    drive(1'b1, 32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(0, 3'b110, C_ZERO, 1, 32'd0, 32'd0, 1, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    drive(1'b1, 32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(1, 3'b110, C_ZERO, 1, 32'd0, 32'd0, 1, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    // add x3,x1,x1 reads cleared x1; write x5=0x55
    drive(1'b0, 32'h001081B3, 32'h00, 1'b1, 5'd5, 32'h55, 1'b0);
    expect_step(2, 3'b110, C_R, 1, 32'd0, 32'd0, 1, 32'd0, 32'h00, 5'd1, 5'd1, 5'd3, 3'd0);
    // addi x1,x0,5
    drive(1'b0, 32'h00500093, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(3, 3'b110, C_I, 1, 32'd0, 32'h55, 1, 32'd5, 32'h10, 5'd0, 5'd5, 5'd1, 3'd0);
    // add x6,x5,x0 during WB of x5
    drive(1'b0, 32'h00028333, 32'h20, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    expect_step(4, 3'b110, C_R, 1, BYP_X5, 32'd0, 1, 32'd0, 32'h20, 5'd5, 5'd0, 5'd6, 3'd0);
    drive(1'b0, 32'h00028333, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(5, 3'b110, C_R, 1, 32'hDEADBEEF, 32'd0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    // write x0 while reading x0, then read x0 again
    drive(1'b0, 32'h000003B3, 32'h24, 1'b1, 5'd0, 32'h1234, 1'b0);
    expect_step(6, 3'b110, C_R, 1, 32'd0, 32'd0, 1, 32'd0, 32'h24, 5'd0, 5'd0, 5'd7, 3'd0);
    drive(1'b0, 32'h000003B3, 32'h24, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(7, 3'b110, C_R, 1, 32'd0, 32'd0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    // illegal opcode 0x7F
    drive(1'b0, 32'h0000007F, 32'h28, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(8, 3'b110, C_ZERO, 0, 32'd0, 32'd0, 1, 32'd0, 32'h28, 5'd0, 5'd0, 5'd0, 3'd0);
    // load-use: lw x2,0(x1); add x3,x2,x2 stalls one cycle
    drive(1'b0, 32'h0000A103, 32'h30, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(9, 3'b110, C_LW, 1, 32'd0, 32'd0, 1, 32'd0, 32'h30, 5'd1, 5'd0, 5'd2, 3'd2);
    drive(1'b0, 32'h002101B3, 32'h34, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(10, 3'b000, C_ZERO, 0, 32'd0, 32'd0, 1, 32'd0, 32'h34, 5'd2, 5'd2, 5'd3, 3'd0);
    drive(1'b0, 32'h002101B3, 32'h34, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(11, 3'b110, C_R, 0, 32'd0, 32'd0, 1, 32'd0, 32'h34, 5'd2, 5'd2, 5'd3, 3'd0);
    // branch taken in the load-use cycle: flush wins over stall
    drive(1'b0, 32'h0000A103, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(12, 3'b110, C_LW, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    drive(1'b0, 32'h002101B3, 32'h44, 1'b0, 5'd0, 32'd0, 1'b1);
    expect_step(13, 3'b111, C_ZERO, 0, 32'd0, 32'd0, 1, 32'd0, 32'h44, 5'd2, 5'd2, 5'd3, 3'd0);
    drive(1'b0, 32'h00500093, 32'h50, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(14, 3'b110, C_I, 1, 32'd0, 32'hDEADBEEF, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    // lui x4,0x12345 / beq x1,x2,-8 / jal x1,-4 / sw x2,12(x1) / sra x5,x6,x7
    drive(1'b0, 32'h12345237, 32'h54, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(15, 3'b110, C_LUI, 0, 32'd0, 32'd0, 1, 32'h12345000, 32'h54, 5'd8, 5'd3, 5'd4, 3'd5);
    drive(1'b0, 32'hFE208CE3, 32'h60, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(16, 3'b110, C_BEQ, 0, 32'd0, 32'd0, 1, 32'hFFFFFFF8, 32'h60, 5'd1, 5'd2, 5'd25, 3'd0);
    drive(1'b0, 32'hFFDFF0EF, 32'h64, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(17, 3'b110, C_JAL, 0, 32'd0, 32'd0, 1, 32'hFFFFFFFC, 32'h64, 5'd31, 5'd29, 5'd1, 3'd7);
    drive(1'b0, 32'h0020A623, 32'h68, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(18, 3'b110, C_SW, 0, 32'd0, 32'd0, 1, 32'd12, 32'h68, 5'd1, 5'd2, 5'd12, 3'd2);
    drive(1'b0, 32'h407352B3, 32'h6C, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(19, 3'b110, C_SRA, 0, 32'd0, 32'd0, 1, 32'd0, 32'h6C, 5'd6, 5'd7, 5'd5, 3'd5);
    // reset in the stall cycle discards the stalled add and clears registers
    drive(1'b0, 32'h0000A103, 32'h70, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(20, 3'b110, C_LW, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    drive(1'b1, 32'h002101B3, 32'h74, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(21, 3'b110, C_ZERO, 1, 32'd0, 32'd0, 1, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    drive(1'b0, 32'h00028333, 32'h78, 1'b0, 5'd0, 32'd0, 1'b0);
    expect_step(22, 3'b110, C_R, 1, 32'd0, 32'd0, 1, 32'd0, 32'h78, 5'd5, 5'd0, 5'd6, 3'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
